// File: rtl/dual_sync_ram16_pkg.sv
// Shared constants and types for the 16x8 simple dual-port synchronous RAM.
package dual_sync_ram16_pkg;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int ADDR  = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [ADDR-1:0]  addr_t;

endpackage : dual_sync_ram16_pkg

// File: rtl/dual_sync_ram16_array.sv
// Storage array for dual_sync_ram16: synchronous clear of every word, one
// write port, and an asynchronous look-up of the addressed word that the
// top level registers.
module dual_sync_ram16_array
    import dual_sync_ram16_pkg::*;
#(
    parameter int depth = DEPTH,
    parameter int width = WIDTH,
    parameter int addr  = ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [addr-1:0]  wraddr,
    input  logic [width-1:0] din,
    input  logic [addr-1:0]  rdaddr,
    output logic [width-1:0] rd_word
);

    logic [width-1:0] mem_r [depth];

    // Clear every word on reset; otherwise store din at wraddr when wr is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= {width{1'b0}};
            end
        end else if (wr) begin
            mem_r[wraddr] <= din;
        end else begin
            mem_r[wraddr] <= mem_r[wraddr];
        end
    end

    // Stored word at the read address; this is the pre-write (old) contents.
    assign rd_word = mem_r[rdaddr];

endmodule : dual_sync_ram16_array

// File: rtl/dual_sync_ram16.sv
// dual_sync_ram16: 16 x 8 simple dual-port synchronous RAM, one clock,
// synchronous active-high reset, registered read data.
// Same-address read-during-write is read-first by default; defining
// DUAL_SYNC_RAM16_WR_BYPASS_EN makes it write-first (dout takes din).
module dual_sync_ram16
    import dual_sync_ram16_pkg::*;
#(
    parameter int depth = DEPTH,
    parameter int width = WIDTH,
    parameter int addr  = ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [addr-1:0]  rdaddr,
    input  logic [addr-1:0]  wraddr,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] mem_word_s;
    logic [width-1:0] rd_data_s;
    logic [width-1:0] dout_r;

    dual_sync_ram16_array #(
        .depth (depth),
        .width (width),
        .addr  (addr)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .wraddr  (wraddr),
        .din     (din),
        .rdaddr  (rdaddr),
        .rd_word (mem_word_s)
    );

`ifdef DUAL_SYNC_RAM16_WR_BYPASS_EN
    // Write-first collision handling: forward din when reading the word being written.
    always_comb begin
        rd_data_s = mem_word_s;
        if (wr && (rdaddr == wraddr)) begin
            rd_data_s = din;
        end else begin
            rd_data_s = mem_word_s;
        end
    end
`else
    // Read-first collision handling: always return the stored (old) word.
    always_comb begin
        rd_data_s = mem_word_s;
    end
`endif

    // Read register: cleared on reset, loaded on rd, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= {width{1'b0}};
        end else if (rd) begin
            dout_r <= rd_data_s;
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule : dual_sync_ram16

// File: tb/tb_dual_sync_ram16.sv
// Self-checking bench for dual_sync_ram16 using an expected-value scoreboard.
module tb_dual_sync_ram16;

`ifdef DUAL_SYNC_RAM16_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [3:0] rdaddr;
    logic [3:0] wraddr;
    logic [7:0] din;
    logic [7:0] dout;

    logic [7:0] model_mem [16];
    logic [7:0] model_dout;
    logic [7:0] exp_q [$];
    string      tag_q [$];

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    dual_sync_ram16 dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .rd     (rd),
        .rdaddr (rdaddr),
        .wraddr (wraddr),
        .din    (din),
        .dout   (dout)
    );

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: dout=0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict dout, then compare it one time unit after the edge.
    task automatic cycle(input string tag, input logic r, input logic w,
                         input logic [3:0] wa, input logic [7:0] d,
                         input logic rd_i, input logic [3:0] ra);
        rst    = r;
        wr     = w;
        wraddr = wa;
        din    = d;
        rd     = rd_i;
        rdaddr = ra;
        if (r) begin
            for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
            model_dout = 8'h00;
        end else begin
            if (rd_i) begin
                if (BYPASS && w && (wa == ra)) model_dout = d;
                else                           model_dout = model_mem[ra];
            end
            if (w) model_mem[wa] = d;
        end
        exp_q.push_back(model_dout);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks_total++;
            $display("FAIL scoreboard: queue empty, dout=0x%02h", dout);
        end else begin
            check_value(tag_q.pop_front(), dout, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] rv;
        model_dout = 8'h00;

        // Reset and read-after-reset
        cycle("reset",     1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        cycle("rst_rd0",   1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
        cycle("rst_rd5",   1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        cycle("rst_rd15",  1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
        check_value("plan_rst_rd15", dout, 8'h00);

        // Back-to-back writes then reads
        cycle("wr5",       1'b0, 1'b1, 4'd5, 8'h24, 1'b0, 4'd0);
        cycle("wr6",       1'b0, 1'b1, 4'd6, 8'h81, 1'b0, 4'd0);
        cycle("wr7",       1'b0, 1'b1, 4'd7, 8'h09, 1'b0, 4'd0);
        cycle("rd5",       1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        check_value("plan_rd5", dout, 8'h24);
        cycle("rd6",       1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd6);
        check_value("plan_rd6", dout, 8'h81);
        cycle("rd7",       1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        check_value("plan_rd7", dout, 8'h09);

        // Read hold with rd low
        for (int i = 0; i < 3; i++) begin
            cycle("hold",  1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd5);
            check_value("plan_hold", dout, 8'h09);
        end

        // Simultaneous read/write to different addresses
        cycle("wr3_rd7",   1'b0, 1'b1, 4'd3, 8'h63, 1'b1, 4'd7);
        check_value("plan_wr3_rd7", dout, 8'h09);
        cycle("rd3",       1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        check_value("plan_rd3", dout, 8'h63);

        // Same-address collision
        cycle("collide5",  1'b0, 1'b1, 4'd5, 8'hFF, 1'b1, 4'd5);
        check_value("plan_collide5", dout, BYPASS ? 8'hFF : 8'h24);
        cycle("rd5_after", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
        check_value("plan_rd5_after", dout, 8'hFF);

        // Reset mid-operation discards write and read
        cycle("rst_midop", 1'b1, 1'b1, 4'd9, 8'h3C, 1'b1, 4'd9);
        check_value("plan_rst_midop", dout, 8'h00);
        cycle("rd9",       1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
        check_value("plan_rd9", dout, 8'h00);

        // Fill every word, reset, and confirm every word was cleared
        for (int i = 0; i < 16; i++) begin
            cycle("fill", 1'b0, 1'b1, 4'(i), 8'(i * 17 + 1), 1'b1, 4'(15 - i));
        end
        for (int i = 0; i < 16; i++) begin
            cycle("fill_rd", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
        end
        cycle("reset2",    1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            cycle("clr_rd", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
            check_value("plan_clr_rd", dout, 8'h00);
        end

        // Random traffic with occasional reset and frequent collisions
        for (int i = 0; i < 400; i++) begin
            rv = $urandom;
            cycle("rand", (rv[4:0] == 5'd0), rv[5], rv[9:6], rv[17:10], rv[18],
                  rv[19] ? rv[9:6] : rv[23:20]);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_dual_sync_ram16
